pacman_turn_ctrl: RTL and testbench
===================================

PACMAN_TURN_CTRL -- requirements
Module: pacman_turn_ctrl

Interface
REQ-001 SHALL provide parameter TILE_BITS, default 4, meaning log2 of tile size in pixels (16-px tiles).
REQ-002 SHALL provide parameter PEND_FRAMES, default 16, meaning the number of frames a buffered turn request survives.
REQ-003 Clk  input  1  system clock (50 MHz); the block uses this one clock only.
REQ-004 Reset_n  input  1  reset, asynchronous and active-low.
REQ-005 keycode  input  8  USB HID keycode from the SoC; W=0x1A, A=0x04, S=0x16, D=0x07; all other values are ignored.
REQ-006 frame_vs  input  1  VGA vertical sync, asynchronous to Clk.
REQ-007 pos_x, pos_y  input  10 each  current Pac-Man position in pixels.
REQ-008 can_move  input  4  maze passability of the next step, indexed by direction.
REQ-009 dir  output  2  committed direction: UP=0, LEFT=1, DOWN=2, RIGHT=3.
REQ-010 moving  output  1  high in state MOVING.
REQ-011 move_en  output  1  one-cycle step strobe, issued once per frame while moving.
REQ-012 turn_pending  output  1  high while a buffered request is held.
REQ-013 last_dirX, last_dirY  output  1 each  facing for sprite selection; 1 = right or down, 0 = left or up.

Function
REQ-014 SHALL synchronise frame_vs through 2 flops, then edge-detect it; the internal frame_tick SHALL pulse for one cycle, 3 Clk edges after frame_vs rises.
REQ-015 Decoding a W/A/S/D keycode in any cycle SHALL load that direction into pending_dir, set turn_pending and load pend_cnt with PEND_FRAMES.
REQ-016 A keycode of 0x00, or any unknown keycode, SHALL leave the pending state unchanged; holding a key SHALL reload pend_cnt every cycle.
REQ-017 On each frame_tick with turn_pending set, pend_cnt SHALL decrement; on reaching 0 it SHALL clear turn_pending.
REQ-018 Tile alignment is defined as aligned = (pos_x[TILE_BITS-1:0]==0) && (pos_y[TILE_BITS-1:0]==0).
REQ-019 Decisions SHALL occur only in frame_tick cycles and SHALL use the register values held before that edge; a key arriving in a tick cycle SHALL take effect at the next tick.
REQ-020 Reversal: if pending_dir is the opposite of dir and can_move[pending_dir]=1, the block SHALL commit it regardless of alignment.
REQ-021 Turn: if aligned and can_move[pending_dir]=1, the block SHALL commit pending_dir.
REQ-022 A commit SHALL set dir=pending_dir, clear turn_pending, enter MOVING and update last_dirX (horizontal commits) or last_dirY (vertical commits) only.
REQ-023 The state machine SHALL have states IDLE, MOVING and BLOCKED:
 - IDLE to MOVING on commit only.
 - MOVING to BLOCKED when a tick finds aligned, no commit and can_move[dir]=0.
 - BLOCKED to MOVING on commit.
 - There is no transition back to IDLE except by reset.
REQ-024 move_en SHALL pulse in the cycle after a tick whose resulting state is MOVING, and SHALL never assert in IDLE or BLOCKED.
REQ-025 dir, moving, turn_pending and last_dir* SHALL be registered and SHALL update on the edge that ends the tick cycle; the one exception is key loading per REQ-015.
REQ-026 pend_cnt SHALL be ceil(log2(PEND_FRAMES+1)) bits wide and SHALL never wrap below 0.

Reset
REQ-027 Reset_n low SHALL asynchronously force: state=IDLE, dir=LEFT, moving=0, move_en=0, turn_pending=0, pend_cnt=0, last_dirX=0, last_dirY=0, synchroniser flops=0.
REQ-028 Reset asserted mid-operation SHALL discard any pending request; frame_tick SHALL NOT fire on the first sampled level after release if frame_vs is already high.

Structure
REQ-029 Package pacman_pkg SHALL hold:
 - dir_t enum (UP, LEFT, DOWN, RIGHT);
 - the keycode constants KEY_W, KEY_A, KEY_S, KEY_D;
 - the function opposite(dir_t);
 - the state_t enum.
REQ-030 The synchroniser and edge detector SHALL be the single sub-module vs_edge_sync.

Verification
REQ-031 Reset, then keycode=0x07, pos=(32,48), can_move=4'b1000, one VS pulse -> dir=3, moving=1, last_dirX=1, move_en pulse 4 Clk after VS rise.
REQ-032 MOVING right at pos_x=37, press W with can_move[0]=1 -> no turn at the unaligned tick; turn_pending=1; commit UP at the first tick with pos=(48,48).
REQ-033 MOVING right, press A, can_move[1]=1, pos_x=37 -> dir=LEFT at the next tick, last_dirX=0.
REQ-034 Press S with can_move[2]=0 held, then 16 VS pulses -> turn_pending falls at the 16th tick; dir is unchanged.
REQ-035 Aligned with can_move[dir]=0 and no pending request -> BLOCKED, moving=0, no move_en; then press D with can_move[3]=1 -> MOVING at the next tick.
REQ-036 Drop Reset_n mid-pend while MOVING -> all outputs return to the REQ-027 values immediately, with no Clk edge required.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types, keycodes and helpers for the Pac-Man turn controller.
package pacman_pkg;

  // Movement directions; opposite directions differ only in bit 1.
  typedef enum logic [1:0] {
    UP    = 2'd0,
    LEFT  = 2'd1,
    DOWN  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  // Controller state; IDLE is only reachable through reset.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVING  = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  // USB HID keycodes for the W/A/S/D keys.
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  // Reverse of a direction: flip the vertical/horizontal sense bit.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  // True when the keycode is one of the four movement keys.
  function automatic logic key_is_dir(input logic [7:0] k);
    return (k == KEY_W) || (k == KEY_A) || (k == KEY_S) || (k == KEY_D);
  endfunction

  // Direction encoded by a movement key; only meaningful when key_is_dir(k).
  function automatic dir_t key_to_dir(input logic [7:0] k);
    dir_t d;
    case (k)
      KEY_W:   d = UP;
      KEY_A:   d = LEFT;
      KEY_S:   d = DOWN;
      default: d = RIGHT;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// Brings the asynchronous VGA vertical sync into the Clk domain and turns
// its rising edge into a single-cycle frame_tick, three Clk edges after the
// rise.
module vs_edge_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_vs,
  output logic frame_tick
);

  // sync_q[0], sync_q[1]: two-flop synchroniser; sync_q[2]: previous level.
  logic [2:0] sync_q;
  // valid_q[2] marks that sync_q[2] holds a real post-reset sample, so a VS
  // that is already high at reset release is not mistaken for a rising edge.
  logic [2:0] valid_q;
  logic       tick_q;
  logic       tick_d;

  // Rising edge seen on the synchronised level, once the history is real.
  always_comb begin
    tick_d = sync_q[1] & ~sync_q[2] & valid_q[2];
  end

  // Synchroniser, edge history and registered tick pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q  <= '0;
      valid_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], frame_vs};
      valid_q <= {valid_q[1:0], 1'b1};
      tick_q  <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/pacman_turn_ctrl.sv
// Pac-Man direction controller: buffers W/A/S/D turn requests for a number
// of frames and commits them once per frame when the maze allows the move.
module pacman_turn_ctrl
  import pacman_pkg::*;
#(
  parameter int TILE_BITS   = 4,
  parameter int PEND_FRAMES = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic       frame_vs,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic [3:0] can_move,
  output logic [1:0] dir,
  output logic       moving,
  output logic       move_en,
  output logic       turn_pending,
  output logic       last_dirX,
  output logic       last_dirY
);

  localparam int CNT_W = $clog2(PEND_FRAMES + 1);

  logic frame_tick;

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  dir_t       pend_dir_q, pend_dir_d;
  logic       pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       last_x_q, last_x_d;
  logic       last_y_q, last_y_d;
  logic       move_en_q, move_en_d;

  logic aligned;
  logic commit;
  logic key_hit;
  dir_t key_dir;
  logic unused_pos;

  vs_edge_sync u_vs_edge_sync (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_vs   (frame_vs),
    .frame_tick (frame_tick)
  );

  // Only the sub-tile offset matters for alignment.
  assign unused_pos = ^{pos_x[9:TILE_BITS], pos_y[9:TILE_BITS]};
  assign aligned    = (pos_x[TILE_BITS-1:0] == '0) && (pos_y[TILE_BITS-1:0] == '0);

  assign key_hit = key_is_dir(keycode);
  assign key_dir = key_to_dir(keycode);

  // A reversal may happen mid-tile; any other turn waits for tile alignment.
  assign commit = frame_tick && pend_q && can_move[pend_dir_q] &&
                  (aligned || (pend_dir_q == opposite(dir_q)));

  // Per-frame decision from pre-tick register values, then key loading,
  // which wins so that a key in a tick cycle is honoured at the next tick.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    pend_dir_d = pend_dir_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    last_x_d   = last_x_q;
    last_y_d   = last_y_q;
    move_en_d  = 1'b0;

    if (frame_tick) begin
      if (commit) begin
        dir_d   = pend_dir_q;
        pend_d  = 1'b0;
        cnt_d   = '0;
        state_d = MOVING;
        if ((pend_dir_q == LEFT) || (pend_dir_q == RIGHT)) begin
          last_x_d = (pend_dir_q == RIGHT);
        end else begin
          last_y_d = (pend_dir_q == DOWN);
        end
      end else begin
        // Age the buffered request; saturate at zero rather than wrap.
        if (pend_q) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d  = '0;
            pend_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        if ((state_q == MOVING) && aligned && !can_move[dir_q]) begin
          state_d = BLOCKED;
        end
      end
      move_en_d = (state_d == MOVING);
    end

    if (key_hit) begin
      pend_dir_d = key_dir;
      pend_d     = 1'b1;
      cnt_d      = CNT_W'(PEND_FRAMES);
    end
  end

  // Controller state registers with asynchronous reset to the idle facing.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      dir_q      <= LEFT;
      pend_dir_q <= LEFT;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      last_x_q   <= 1'b0;
      last_y_q   <= 1'b0;
      move_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      pend_dir_q <= pend_dir_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      last_x_q   <= last_x_d;
      last_y_q   <= last_y_d;
      move_en_q  <= move_en_d;
    end
  end

  assign dir          = dir_q;
  assign moving       = (state_q == MOVING);
  assign move_en      = move_en_q;
  assign turn_pending = pend_q;
  assign last_dirX    = last_x_q;
  assign last_dirY    = last_y_q;

endmodule

// File: tb/tb_pacman_turn_ctrl.sv
// Scoreboard bench for pacman_turn_ctrl: stimulus queues the expected
// output snapshot for a given cycle, a monitor compares at that cycle.
module tb_pacman_turn_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] keycode;
  logic       frame_vs;
  logic [9:0] pos_x, pos_y;
  logic [3:0] can_move;
  logic [1:0] dir;
  logic       moving, move_en, turn_pending, last_dirX, last_dirY;

  pacman_turn_ctrl #(.TILE_BITS(4), .PEND_FRAMES(16)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .keycode      (keycode),
    .frame_vs     (frame_vs),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .can_move     (can_move),
    .dir          (dir),
    .moving       (moving),
    .move_en      (move_en),
    .turn_pending (turn_pending),
    .last_dirX    (last_dirX),
    .last_dirY    (last_dirY)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] d;
    logic       mv, pd, lx, ly, me;
    int         me_cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_me = 0;
  int   me_seen = 0;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_at(input int c, input string nm, input logic [1:0] d,
                           input logic mv, input logic pd, input logic lx,
                           input logic ly, input logic me);
    exp_t e;
    e.cyc = c; e.name = nm; e.d = d; e.mv = mv; e.pd = pd;
    e.lx = lx; e.ly = ly; e.me = me; e.me_cnt = exp_me;
    sb.push_back(e);
  endtask

  // One-cycle key press; expected snapshot after the loading edge.
  task automatic press(input logic [7:0] k, input string nm, input logic [1:0] d,
                       input logic mv, input logic pd, input logic lx, input logic ly);
    expect_at(cyc + 1, nm, d, mv, pd, lx, ly, 1'b0);
    keycode = k;
    step();
    keycode = 8'h00;
  endtask

  // One VS pulse: decision lands on edge P+4, move_en high there only.
  task automatic frame(input logic [1:0] d, input logic mv, input logic pd,
                       input logic lx, input logic ly, input logic me,
                       input string nm, input logic [7:0] tick_key);
    int p;
    p = cyc;
    if (me) exp_me++;
    expect_at(p + 4, nm, d, mv, pd, lx, ly, me);
    expect_at(p + 5, {nm, "_after"}, d, mv, pd, lx, ly, 1'b0);
    frame_vs = 1'b1;
    repeat (3) step();
    if (tick_key != 8'h00) keycode = tick_key;
    step();
    keycode = 8'h00;
    repeat (2) step();
    frame_vs = 1'b0;
    repeat (3) step();
  endtask

  // Monitor: count move_en pulses, compare the entry due this cycle.
  initial begin
    forever begin
      @(negedge Clk);
      if (move_en === 1'b1) me_seen++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL %s: entry for cycle %0d not checked, now cycle %0d", e.name, e.cyc, cyc);
        end else if (dir !== e.d || moving !== e.mv || turn_pending !== e.pd ||
                     last_dirX !== e.lx || last_dirY !== e.ly || move_en !== e.me ||
                     me_seen != e.me_cnt) begin
          errors++;
          $display("FAIL %s: got dir=%0d mv=%b pend=%b lx=%b ly=%b me=%b pulses=%0d, want dir=%0d mv=%b pend=%b lx=%b ly=%b me=%b pulses=%0d",
                   e.name, dir, moving, turn_pending, last_dirX, last_dirY, move_en, me_seen,
                   e.d, e.mv, e.pd, e.lx, e.ly, e.me, e.me_cnt);
        end else begin
          $display("ok   %s: dir=%0d mv=%b pend=%b lx=%b ly=%b me=%b", e.name,
                   dir, moving, turn_pending, last_dirX, last_dirY, move_en);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset_n = 1'b0; keycode = 8'h00; frame_vs = 1'b0;
    pos_x = 10'd32; pos_y = 10'd48; can_move = 4'b0000;
    expect_at(2, "reset_hold", 2'd1, 0, 0, 0, 0, 0);
    repeat (3) step();
    Reset_n = 1'b1;
    repeat (5) step();
    expect_at(cyc + 1, "post_reset", 2'd1, 0, 0, 0, 0, 0);
    step();

    // First move right from idle.
    pos_x = 10'd32; pos_y = 10'd48; can_move = 4'b1000;
    press(8'h07, "t1_key_d", 2'd1, 0, 1, 0, 0);
    expect_at(cyc + 3, "t1_pre_tick", 2'd1, 0, 1, 0, 0, 0);
    frame(2'd3, 1, 0, 1, 0, 1, "t1_commit_right", 8'h00);

    // Unaligned turn request waits for alignment.
    pos_x = 10'd37; can_move = 4'b0001;
    press(8'h1A, "t2_key_w", 2'd3, 1, 1, 1, 0);
    frame(2'd3, 1, 1, 1, 0, 1, "t2_unaligned_hold", 8'h00);
    pos_x = 10'd48;
    frame(2'd0, 1, 0, 1, 0, 1, "t2_commit_up", 8'h00);

    // Aligned turn right, then mid-tile reversal to left.
    can_move = 4'b1000;
    press(8'h07, "t3_key_d", 2'd0, 1, 1, 1, 0);
    frame(2'd3, 1, 0, 1, 0, 1, "t3_turn_right", 8'h00);
    pos_x = 10'd37; can_move = 4'b0010;
    press(8'h04, "t3_key_a", 2'd3, 1, 1, 1, 0);
    frame(2'd1, 1, 0, 0, 0, 1, "t3_reverse_left", 8'h00);

    // Blocked request expires on the 16th tick; unknown key ignored.
    press(8'h16, "t4_key_s", 2'd1, 1, 1, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      if (i == 4) press(8'h55, "t4_unknown_key", 2'd1, 1, 1, 0, 0);
      frame(2'd1, 1, (i < 16), 0, 0, 1, $sformatf("t4_expire_%0d", i), 8'h00);
    end

    // Wall ahead at a tile boundary blocks, then a key unblocks.
    pos_x = 10'd48; pos_y = 10'd48; can_move = 4'b1000;
    frame(2'd1, 0, 0, 0, 0, 0, "t5_blocked", 8'h00);
    frame(2'd1, 0, 0, 0, 0, 0, "t5_still_blocked", 8'h00);
    press(8'h07, "t5_key_d", 2'd1, 0, 1, 0, 0);
    frame(2'd3, 1, 0, 1, 0, 1, "t5_unblock_right", 8'h00);
    can_move = 4'b0100;
    press(8'h16, "t5_key_s", 2'd3, 1, 1, 1, 0);
    frame(2'd2, 1, 0, 1, 1, 1, "t5_turn_down", 8'h00);

    // Key arriving in the tick cycle applies at the following tick.
    can_move = 4'b0101;
    frame(2'd2, 1, 1, 1, 1, 1, "t6_key_in_tick", 8'h1A);
    frame(2'd0, 1, 0, 1, 0, 1, "t6_commit_up", 8'h00);

    // Asynchronous reset mid-pend, release with VS already high.
    pos_x = 10'd37; can_move = 4'b0001;
    press(8'h16, "t7_key_s", 2'd0, 1, 1, 1, 0);
    step();
    expect_at(cyc, "t7_async_reset", 2'd1, 0, 0, 0, 0, 0);
    Reset_n = 1'b0;
    frame_vs = 1'b1;
    repeat (2) step();
    Reset_n = 1'b1;
    pos_x = 10'd48; pos_y = 10'd48; can_move = 4'b1000;
    step();
    press(8'h07, "t7_key_d", 2'd1, 0, 1, 0, 0);
    repeat (4) step();
    expect_at(cyc + 1, "t7_no_spurious_tick", 2'd1, 0, 1, 0, 0, 0);
    step();
    frame_vs = 1'b0;
    repeat (4) step();
    frame(2'd3, 1, 0, 1, 0, 1, "t7_first_real_tick", 8'h00);

    repeat (10) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d entries unchecked, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
